// File: rtl/adder_pkg.sv
// Shared types for the sequential chunked adder: FSM state encoding and result flags.
package adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } adder_state_e;

  typedef struct packed {
    logic cout;
    logic ovf;
  } result_flags_t;

endpackage : adder_pkg

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple-carry adder; also exposes the carry into its MSB.
module chunk_adder #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [CHUNK:0] carry;

  assign carry[0] = ci;

  for (genvar i = 0; i < int'(CHUNK); i++) begin : g_bit
    assign s[i]       = x[i] ^ y[i] ^ carry[i];
    assign carry[i+1] = (x[i] & y[i]) | (carry[i] & (x[i] ^ y[i]));
  end

  assign co    = carry[CHUNK];
  assign c_msb = carry[CHUNK-1];

endmodule : chunk_adder

// File: rtl/seq_chunk_adder.sv
// Multi-cycle WIDTH-bit add/subtract, CHUNK bits per clock with a registered inter-chunk carry.
module seq_chunk_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned N  = WIDTH / CHUNK;
  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

  if ((WIDTH < 2) || (CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
    $error("seq_chunk_adder: illegal WIDTH/CHUNK combination");
  end

  adder_state_e  state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d, sum_q, sum_d;
  logic          carry_q, carry_d;
  logic [KW-1:0] k_q, k_d;
  result_flags_t flags_q, flags_d;

  logic [31:0]      base;
  logic [CHUNK-1:0] cx, cy, cs;
  logic             cco, cmsb;

  // Select the operand slice for the chunk currently being processed.
  always_comb begin
    base = 32'(k_q) * 32'(CHUNK);
    cx   = a_q[base +: CHUNK];
    cy   = b_q[base +: CHUNK];
  end

  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .x     (cx),
    .y     (cy),
    .ci    (carry_q),
    .s     (cs),
    .co    (cco),
    .c_msb (cmsb)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    k_d     = k_q;
    flags_d = flags_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          acc_d   = '0;
          k_d     = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        acc_d[base +: CHUNK] = cs;
        carry_d = cco;
        if (k_q == KW'(N - 1)) begin
          // Last chunk: publish the assembled result and flags together.
          sum_d         = acc_d;
          flags_d.cout  = cco;
          flags_d.ovf   = cco ^ cmsb;
          k_d           = '0;
          state_d       = S_DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      k_q     <= k_d;
      flags_q <= flags_d;
    end
  end

  // Handshake outputs decode registered state only; in_ready is forced low during reset.
  assign in_ready  = rst_n && (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign sum       = sum_q;
  assign cout      = flags_q.cout;
  assign ovf       = flags_q.ovf;

endmodule : seq_chunk_adder

// File: tb/tb_seq_chunk_adder.sv
// Directed bench for seq_chunk_adder: 16/4 instance plus 8/8 and 8/1 corner instances.
module tb_seq_chunk_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 16-bit, 4-bit chunk instance
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [15:0] a, b, sum;

  // Two 8-bit instances share one stimulus set
  logic       v8, cin8, sub8, ordy8;
  logic [7:0] a8, b8;
  logic       rdy8a, ov8a, co8a, of8a, rdy8b, ov8b, co8b, of8b;
  logic [7:0] s8a, s8b;

  int n_vec = 0;
  int n_err = 0;
  int lat;
  int lat_a, lat_b;

  seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) u8a (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy8a),
    .a(a8), .b(b8), .cin(cin8), .sub(sub8), .out_valid(ov8a),
    .out_ready(ordy8), .sum(s8a), .cout(co8a), .ovf(of8a)
  );

  seq_chunk_adder #(.WIDTH(8), .CHUNK(1)) u8b (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy8b),
    .a(a8), .b(b8), .cin(cin8), .sub(sub8), .out_valid(ov8b),
    .out_ready(ordy8), .sum(s8b), .cout(co8b), .ovf(of8b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accept one operation on u16, then count edges until out_valid (-1 on timeout).
  task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tc, input logic ts,
                       output int l);
    int guard = 0;
    while (!in_ready && guard < 50) begin step(); guard++; end
    a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    l = -1;
    for (int i = 1; i <= 50; i++) begin
      if (out_valid) begin l = i - 1; break; end
      step();
    end
    if (l < 0 && out_valid) l = 50;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic chk_res(input string tag, input logic [15:0] es, input logic ec, input logic eo);
    chk({tag, "_sum"}, 32'(sum), 32'(es));
    chk({tag, "_cout"}, 32'(cout), 32'(ec));
    chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    v8 = 1'b0; ordy8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;

    step(); step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    step();
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    do_op(16'h00FF, 16'h0F01, 1'b0, 1'b0, lat);
    chk("add1_latency", 32'(lat), 32'd4);
    chk_res("add1", 16'h1000, 1'b0, 1'b0);
    consume();
    chk("add1_released", 32'(out_valid), 32'd0);

    do_op(16'hFFFF, 16'h0001, 1'b1, 1'b0, lat);
    chk_res("add_cin", 16'h0001, 1'b1, 1'b0);
    consume();

    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat);
    chk_res("add_ovf", 16'h8000, 1'b0, 1'b1);
    consume();

    do_op(16'h0005, 16'h0007, 1'b1, 1'b1, lat);
    chk_res("sub_borrow", 16'hFFFE, 1'b0, 1'b0);
    consume();

    do_op(16'h8000, 16'h0001, 1'b0, 1'b1, lat);
    chk_res("sub_ovf", 16'h7FFF, 1'b1, 1'b1);

    // Back-pressure with new operands offered the whole time.
    a = 16'h1234; b = 16'h0001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk_res("bp", 16'h7FFF, 1'b1, 1'b1);
    end
    a = 16'h0001; b = 16'h0002;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("hs_out_valid", 32'(out_valid), 32'd0);
    chk("hs_in_ready", 32'(in_ready), 32'd1);
    chk("hs_sum_hold", 32'(sum), 32'h7FFF);
    step();
    in_valid = 1'b0;
    chk("next_accepted", 32'(in_ready), 32'd0);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (out_valid) begin lat = i; break; end
    end
    chk("next_latency", 32'(lat), 32'd4);
    chk("next_sum", 32'(sum), 32'h0003);
    consume();

    // Reset two chunk edges into an operation.
    a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    rst_n = 1'b0;
    step();
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_in_ready_low", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("abort_no_result", 32'(out_valid), 32'd0);
    end
    do_op(16'h1234, 16'h1111, 1'b0, 1'b0, lat);
    chk("post_abort_latency", 32'(lat), 32'd4);
    chk_res("post_abort", 16'h2345, 1'b0, 1'b0);
    consume();

    // 8-bit instances: full-width chunk and single-bit chunks.
    chk("w8a_ready", 32'(rdy8a), 32'd1);
    chk("w8b_ready", 32'(rdy8b), 32'd1);
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; sub8 = 1'b0; v8 = 1'b1;
    step();
    v8 = 1'b0;
    lat_a = -1; lat_b = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (ov8a && lat_a < 0) lat_a = i;
      if (ov8b && lat_b < 0) lat_b = i;
    end
    chk("w8a_latency", 32'(lat_a), 32'd1);
    chk("w8b_latency", 32'(lat_b), 32'd8);
    chk("w8a_sum", 32'(s8a), 32'h00);
    chk("w8a_cout", 32'(co8a), 32'd1);
    chk("w8a_ovf", 32'(of8a), 32'd1);
    chk("w8b_sum", 32'(s8b), 32'h00);
    chk("w8b_cout", 32'(co8b), 32'd1);
    chk("w8b_ovf", 32'(of8b), 32'd1);
    ordy8 = 1'b1;
    step();
    ordy8 = 1'b0;
    chk("w8a_released", 32'(ov8a), 32'd0);
    chk("w8b_released", 32'(ov8b), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_seq_chunk_adder
